// File: rtl/linear_trans_spn_iter.sv
// Iterative GF(2^WORD_W) linear diffusion layer over five lanes.
// Accepts one block, applies T to it N times (one application per cycle), then holds the result.
module linear_trans_spn_iter #(
  parameter int unsigned          WORD_W  = 24,
  parameter int unsigned          PAD_W   = 8,
  parameter logic [WORD_W-1:0]    POLY    = 'h00001B,
  parameter int unsigned          ITER_W  = 4,
  localparam int unsigned         BLOCK_W = 5 * WORD_W + PAD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [ITER_W-1:0]  in_iter,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [BLOCK_W-1:0] data_q;
  logic [ITER_W-1:0]  cnt_q;
  logic [BLOCK_W-1:0] data_t;

  // Multiply by x in GF(2^WORD_W), reducing by the implicit top bit plus POLY.
  function automatic logic [WORD_W-1:0] x2(input logic [WORD_W-1:0] v);
    logic [WORD_W-1:0] r;
    r = {v[WORD_W-2:0], 1'b0};
    if (v[WORD_W-1]) begin
      r = r ^ POLY;
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] x4(input logic [WORD_W-1:0] v);
    return x2(x2(v));
  endfunction

  function automatic logic [BLOCK_W-1:0] transform(input logic [BLOCK_W-1:0] blk);
    logic [WORD_W-1:0]  a0, a1, a2, a3, a4;
    logic [WORD_W-1:0]  y0, y1, y2, y3, y4;
    logic [BLOCK_W-1:0] r;
    a0 = blk[0*WORD_W +: WORD_W];
    a1 = blk[1*WORD_W +: WORD_W];
    a2 = blk[2*WORD_W +: WORD_W];
    a3 = blk[3*WORD_W +: WORD_W];
    a4 = blk[4*WORD_W +: WORD_W];
    y0 = x4(a1 ^ a3) ^ x2(a2 ^ a4) ^ a0 ^ a2 ^ a3;
    y1 = x4(a2 ^ a4) ^ x2(a0 ^ a3) ^ a1 ^ a3 ^ a4;
    y2 = x4(a0 ^ a3) ^ x2(a1 ^ a4) ^ a0 ^ a2 ^ a4;
    y3 = x4(a1 ^ a4) ^ x2(a0 ^ a2) ^ a0 ^ a1 ^ a3;
    y4 = x4(a0 ^ a2) ^ x2(a1 ^ a3) ^ a1 ^ a2 ^ a4;
    // Pad field passes straight through every application.
    r = blk;
    r[0*WORD_W +: WORD_W] = y0;
    r[1*WORD_W +: WORD_W] = y1;
    r[2*WORD_W +: WORD_W] = y2;
    r[3*WORD_W +: WORD_W] = y3;
    r[4*WORD_W +: WORD_W] = y4;
    return r;
  endfunction

  always_comb begin
    data_t = transform(data_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q  <= in_data;
            cnt_q   <= in_iter;
            state_q <= (in_iter != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          // Counter is always >= 1 here, so it cannot wrap.
          data_q <= data_t;
          cnt_q  <= cnt_q - ITER_W'(1);
          if (cnt_q == ITER_W'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun);
    out_data  = data_q;
  end

endmodule

// File: tb/tb_linear_trans_spn_iter.sv
// Randomized self-checking bench for linear_trans_spn_iter against a table-driven lane model.
module tb_linear_trans_spn_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   in_iter = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  linear_trans_spn_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_iter  (in_iter),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Multiply by x modulo x^24 + x^4 + x^3 + x + 1, done with integer arithmetic.
  function automatic logic [23:0] gf_dbl(input logic [23:0] v);
    int unsigned w;
    w = v;
    w = (w * 2) % 32'h0100_0000;
    if (v >= 24'h80_0000) w = w ^ 32'h1B;
    return w[23:0];
  endfunction

  function automatic logic [127:0] model_t(input logic [127:0] b);
    logic [23:0]  a[5];
    logic [23:0]  y;
    logic [127:0] r;
    int q4[5][2] = '{'{1, 3}, '{2, 4}, '{0, 3}, '{1, 4}, '{0, 2}};
    int q2[5][2] = '{'{2, 4}, '{0, 3}, '{1, 4}, '{0, 2}, '{1, 3}};
    int pl[5][3] = '{'{0, 2, 3}, '{1, 3, 4}, '{0, 2, 4}, '{0, 1, 3}, '{1, 2, 4}};
    for (int k = 0; k < 5; k++) a[k] = b[k*24 +: 24];
    r = b;
    for (int k = 0; k < 5; k++) begin
      y = gf_dbl(gf_dbl(a[q4[k][0]] ^ a[q4[k][1]])) ^ gf_dbl(a[q2[k][0]] ^ a[q2[k][1]]);
      y = y ^ a[pl[k][0]] ^ a[pl[k][1]] ^ a[pl[k][2]];
      r[k*24 +: 24] = y;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_n(input logic [127:0] b, input int n);
    logic [127:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = model_t(r);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, then wait (bounded) for out_valid; junk is driven on the inputs meanwhile.
  task automatic send_wait(input logic [127:0] d, input logic [3:0] n, output logic [127:0] res,
                           output int lat, output int busy_cnt);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_iter   = n;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data  = rnd128();
    in_iter  = 4'($urandom);
    in_valid = 1'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    res      = out_data;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out_data=%h, want 1 0 0 0",
               in_ready, out_valid, busy, out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unit_vector();
    logic [127:0] res;
    int lat, bc;
    send_wait(128'hA5_000000_000000_000000_000000_000001, 4'd1, res, lat, bc);
    n_checks++;
    if (res !== 128'hA5_000004_000003_000005_000002_000001 || lat != 1) begin
      n_fail++;
      $display("FAIL unit_vector: got %h lat %0d, want A5000004000003000005000002000001 lat 1",
               res, lat);
    end
    consume();
  endtask

  task automatic test_reduction();
    logic [127:0] res, exp_v;
    int lat, bc;
    exp_v = {8'h00, 24'h80001B, 24'h800036, 24'h00001B, 24'h800000, 24'h000036};
    send_wait({8'h00, 24'h0, 24'h0, 24'h0, 24'h800000, 24'h0}, 4'd1, res, lat, bc);
    n_checks++;
    if (res !== exp_v) begin
      n_fail++;
      $display("FAIL reduction: got %h want %h", res, exp_v);
    end
    consume();
  endtask

  task automatic test_bypass();
    logic [127:0] d, res;
    int lat, bc;
    for (int t = 0; t < 3; t++) begin
      d = rnd128();
      send_wait(d, 4'd0, res, lat, bc);
      n_checks++;
      if (res !== d || lat != 0 || bc != 0) begin
        n_fail++;
        $display("FAIL bypass: got %h lat %0d busy %0d, want %h lat 0 busy 0", res, lat, bc, d);
      end
      consume();
    end
  endtask

  task automatic test_iteration();
    logic [127:0] d, res, exp_v;
    int lat, bc;
    d     = rnd128();
    exp_v = model_n(d, 15);
    send_wait(d, 4'd15, res, lat, bc);
    n_checks++;
    if (res !== exp_v || lat != 15 || bc != 15) begin
      n_fail++;
      $display("FAIL iteration15: got %h lat %0d busy %0d, want %h lat 15 busy 15",
               res, lat, bc, exp_v);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [127:0] d, res, exp_v;
    logic [3:0] n;
    int lat, bc;
    for (int t = 0; t < 8; t++) begin
      d     = rnd128();
      n     = 4'($urandom_range(0, 15));
      exp_v = model_n(d, int'(n));
      send_wait(d, n, res, lat, bc);
      n_checks++;
      if (res !== exp_v || lat != int'(n) || bc != int'(n)) begin
        n_fail++;
        $display("FAIL back_to_back n=%0d: got %h lat %0d busy %0d, want %h", n, res, lat, bc,
                 exp_v);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, res, exp_v;
    int lat, bc;
    d     = rnd128();
    exp_v = model_n(d, 3);
    send_wait(d, 4'd3, res, lat, bc);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rnd128();
      in_iter  = 4'($urandom);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure c=%0d: valid=%b data=%h in_ready=%b, want 1 %h 0", c,
                 out_valid, out_data, in_ready, exp_v);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] d, res, exp_v;
    int lat, bc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rnd128();
    in_iter  = 4'd8;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_busy: busy=%b valid=%b, want 1 0", busy, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: valid=%b in_ready=%b data=%h busy=%b, want 0 1 0 0",
               out_valid, in_ready, out_data, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d     = rnd128();
    exp_v = model_n(d, 5);
    send_wait(d, 4'd5, res, lat, bc);
    n_checks++;
    if (res !== exp_v || lat != 5) begin
      n_fail++;
      $display("FAIL after_reset: got %h lat %0d, want %h lat 5", res, lat, exp_v);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_unit_vector();
    test_reduction();
    test_bypass();
    test_iteration();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linear_trans_spn_iter.md
LINEAR_TRANS_SPN_ITER -- requirements
Module: linear_trans_spn_iter

Interface
REQ-001 SHALL have parameter WORD_W, default 24: lane width in bits; 5 lanes per block.
REQ-002 SHALL have parameter PAD_W, default 8: width of the untouched top field.
REQ-003 SHALL have parameter POLY, default 'h00001B (WORD_W bits): low WORD_W bits of the GF(2^WORD_W) reduction polynomial.
REQ-004 SHALL have parameter ITER_W, default 4: width of the iteration-count field.
REQ-005 SHALL define derived BLOCK_W = 5*WORD_W + PAD_W, which is 128 at defaults.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: input block offered.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepted when in_valid and in_ready are both 1 at a clock edge.
REQ-010 SHALL have port in_data, input, BLOCK_W bits: lane k = in_data[(k+1)*WORD_W-1 : k*WORD_W], k = 0..4; pad field = top PAD_W bits.
REQ-011 SHALL have port in_iter, input, ITER_W bits: number of transform applications N, captured on accept.
REQ-012 SHALL have port out_valid, output, 1 bit: result available.
REQ-013 SHALL have port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both 1 at a clock edge.
REQ-014 SHALL have port out_data, output, BLOCK_W bits: result block.
REQ-015 SHALL have port busy, output, 1 bit: 1 in the RUN state.

Function
REQ-016 SHALL define x2(v) for GF(2^WORD_W) as (v<<1) truncated to WORD_W bits, XORed with POLY when v[WORD_W-1]=1; x4(v) SHALL equal x2(x2(v)).
REQ-017 SHALL define transform T on lanes a0..a4 (all XOR) as follows:
  y0 = x4(a1^a3) ^ x2(a2^a4) ^ a0 ^ a2 ^ a3
  y1 = x4(a2^a4) ^ x2(a0^a3) ^ a1 ^ a3 ^ a4
  y2 = x4(a0^a3) ^ x2(a1^a4) ^ a0 ^ a2 ^ a4
  y3 = x4(a1^a4) ^ x2(a0^a2) ^ a0 ^ a1 ^ a3
  y4 = x4(a0^a2) ^ x2(a1^a3) ^ a1 ^ a2 ^ a4
REQ-018 SHALL leave the pad field bit-identical through every application of T.
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE, holding one BLOCK_W state register and an ITER_W down-counter.
REQ-020 SHALL drive in_ready = 1 only in IDLE (combinational from state), so that no input is accepted in RUN or DONE.
REQ-021 In IDLE, on accept, SHALL load the state register with in_data and the counter with in_iter, then go to RUN if in_iter != 0, else go to DONE.
REQ-022 In RUN, at each edge, SHALL replace state with T(state) and decrement the counter; the edge on which the counter goes 1 -> 0 SHALL also move the FSM to DONE.
REQ-023 Timing: with accept at edge E0, out_valid SHALL first be high after edge E_N, i.e. N cycles later (N = 0 gives out_valid right after E0, with data equal to in_data).
REQ-024 In DONE, SHALL hold out_valid = 1 and keep out_data stable until out_ready = 1, then go to IDLE at that edge.
REQ-025 SHALL drive out_data = state register at all times and out_valid = 1 only in DONE.
REQ-026 SHALL ignore in_valid, in_data and in_iter outside IDLE.
REQ-027 Maximum N = 2^ITER_W - 1; the counter SHALL never wrap.

Reset
REQ-028 rst_n = 0 SHALL immediately force IDLE, clear the state register and counter to 0, and set out_valid = 0, busy = 0, in_ready = 1, regardless of the current state.
REQ-029 After rst_n deasserts, the first accept SHALL behave as in REQ-021, with no residue from any aborted operation.

Verification
REQ-030 Unit vector, defaults: in_data = A5_000000_000000_000000_000000_000001, N = 1 -> out_data = A5_000004_000003_000005_000002_000001, 1 cycle after accept.
REQ-031 Reduction: lane1 = 800000, all other lanes and pad = 0, N = 1 -> lanes y4..y0 = 80001B, 800036, 00001B, 800000, 000036.
REQ-032 Bypass: N = 0, any in_data -> out_valid after the accept edge, with out_data = in_data.
REQ-033 Iteration: N = 15, random data -> out_data matches a model applying T 15 times; out_valid rises exactly 15 cycles after accept; busy high for 15 cycles.
REQ-034 Backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready = 0; then out_ready = 1 -> IDLE and in_ready = 1 the next cycle.
REQ-035 Reset mid-RUN: assert rst_n = 0 at iteration 3 of N = 8 -> out_valid = 0, in_ready = 1, out_data = 0 immediately; the next block computes correctly.
